// File: rtl/qpsk_demodulator.sv
// QPSK correlator/demodulator: correlates 8-sample symbols against cos/sin
// references and decides the symbol from the signs of the two sums.
module qpsk_demodulator #(
    parameter int DATA_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] QPSK_in,
    input  logic                     sample_valid,
    input  logic                     align,
    output logic signed [20:0]       i_acc,
    output logic signed [20:0]       q_acc,
    output logic [1:0]               symbol,
    output logic                     sym_valid
);

    localparam int ACC_W  = 21;
    localparam int PROD_W = DATA_W + 8;

    logic [2:0]               phase;
    logic [2:0]               eff_phase;
    logic signed [ACC_W-1:0]  sum_i, sum_q;
    logic signed [ACC_W-1:0]  next_i, next_q;
    logic signed [7:0]        cos_v, sin_v;
    logic signed [PROD_W-1:0] prod_i, prod_q;

    function automatic logic signed [7:0] cos_lut(input logic [2:0] p);
        cos_lut = '0;
        case (p)
            3'd0: cos_lut = 8'sd127;
            3'd1: cos_lut = 8'sd90;
            3'd2: cos_lut = 8'sd0;
            3'd3: cos_lut = -8'sd90;
            3'd4: cos_lut = -8'sd127;
            3'd5: cos_lut = -8'sd90;
            3'd6: cos_lut = 8'sd0;
            3'd7: cos_lut = 8'sd90;
        endcase
    endfunction

    function automatic logic signed [7:0] sin_lut(input logic [2:0] p);
        sin_lut = '0;
        case (p)
            3'd0: sin_lut = 8'sd0;
            3'd1: sin_lut = 8'sd90;
            3'd2: sin_lut = 8'sd127;
            3'd3: sin_lut = 8'sd90;
            3'd4: sin_lut = 8'sd0;
            3'd5: sin_lut = -8'sd90;
            3'd6: sin_lut = -8'sd127;
            3'd7: sin_lut = -8'sd90;
        endcase
    endfunction

    // An align strobe restarts the symbol, so the current sample correlates as phase 0
    // against empty sums.
    always_comb begin
        eff_phase = align ? 3'd0 : phase;
        cos_v     = cos_lut(eff_phase);
        sin_v     = sin_lut(eff_phase);
        prod_i    = $signed({{8{QPSK_in[DATA_W-1]}}, QPSK_in}) * $signed({{DATA_W{cos_v[7]}}, cos_v});
        prod_q    = $signed({{8{QPSK_in[DATA_W-1]}}, QPSK_in}) * $signed({{DATA_W{sin_v[7]}}, sin_v});
        next_i    = (align ? '0 : sum_i) + ACC_W'(prod_i);
        next_q    = (align ? '0 : sum_q) + ACC_W'(prod_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            sum_i     <= '0;
            sum_q     <= '0;
            i_acc     <= '0;
            q_acc     <= '0;
            symbol    <= 2'b00;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            if (sample_valid) begin
                if (!align && phase == 3'd7) begin
                    i_acc     <= next_i;
                    q_acc     <= next_q;
                    symbol    <= {next_i[ACC_W-1], next_q[ACC_W-1]};
                    sym_valid <= 1'b1;
                    sum_i     <= '0;
                    sum_q     <= '0;
                    phase     <= '0;
                end else begin
                    sum_i <= next_i;
                    sum_q <= next_q;
                    phase <= eff_phase + 3'd1;
                end
            end else if (align) begin
                sum_i <= '0;
                sum_q <= '0;
                phase <= '0;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Self-checking bench for qpsk_demodulator: directed symbols plus random traffic
// compared against a queue-based correlation model.
module tb_qpsk_demodulator;

    localparam int DATA_W = 10;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic signed [DATA_W-1:0] QPSK_in = '0;
    logic                     sample_valid = 1'b0;
    logic                     align = 1'b0;
    logic signed [20:0]       i_acc, q_acc;
    logic [1:0]               symbol;
    logic                     sym_valid;

    int checks = 0;
    int errors = 0;

    int cos_tab [8] = '{127, 90, 0, -90, -127, -90, 0, 90};
    int sin_tab [8] = '{0, 90, 127, 90, 0, -90, -127, -90};

    // Reference model: samples of the current symbol, plus the last decided outputs
    int model_q[$];
    int exp_i = 0, exp_q = 0, exp_sym = 0, exp_sv = 0;

    qpsk_demodulator #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .QPSK_in(QPSK_in), .sample_valid(sample_valid),
        .align(align), .i_acc(i_acc), .q_acc(q_acc), .symbol(symbol), .sym_valid(sym_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_i = 0; exp_q = 0; exp_sym = 0; exp_sv = 0;
    endtask

    task automatic model_edge(input bit v, input bit a, input int s);
        int si, sq;
        exp_sv = 0;
        if (a) model_q.delete();
        if (v) begin
            model_q.push_back(s);
            if (model_q.size() == 8) begin
                si = 0; sq = 0;
                foreach (model_q[k]) begin
                    si += model_q[k] * cos_tab[k];
                    sq += model_q[k] * sin_tab[k];
                end
                exp_i   = si;
                exp_q   = sq;
                exp_sym = ((si < 0) ? 2 : 0) + ((sq < 0) ? 1 : 0);
                exp_sv  = 1;
                model_q.delete();
            end
        end
    endtask

    task automatic step(input bit v, input bit a, input int s);
        sample_valid = v;
        align        = a;
        QPSK_in      = s[DATA_W-1:0];
        @(posedge clk);
        #1;
        model_edge(v, a, s);
        chk("sym_valid", sym_valid, exp_sv);
        chk("i_acc", i_acc, exp_i);
        chk("q_acc", q_acc, exp_q);
        chk("symbol", symbol, exp_sym);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_i"}, i_acc, 0);
        chk({tag, "_q"}, q_acc, 0);
        chk({tag, "_sym"}, symbol, 0);
        chk({tag, "_sv"}, sym_valid, 0);
    endtask

    initial begin
        int pulses;
        int v;
        // Reset state
        #2;
        chk_zero("reset");
        #20 rst_n = 1'b1;
        model_reset();
        step(0, 0, 0);

        // cos LUT -> I full correlation, Q zero
        for (int k = 0; k < 8; k++) step(1, 0, cos_tab[k]);
        chk("cos_sv", sym_valid, 1);
        chk("cos_i", i_acc, 64658);
        chk("cos_q", q_acc, 0);
        chk("cos_sym", symbol, 0);
        step(0, 0, 0);
        chk("cos_sv_one_cycle", sym_valid, 0);
        chk("cos_hold_i", i_acc, 64658);

        // negated sin LUT
        for (int k = 0; k < 8; k++) step(1, 0, -sin_tab[k]);
        chk("nsin_i", i_acc, 0);
        chk("nsin_q", q_acc, -64658);
        chk("nsin_sym", symbol, 1);

        // -(cos+sin), then a back-to-back cos symbol
        for (int k = 0; k < 8; k++) step(1, 0, -(cos_tab[k] + sin_tab[k]));
        chk("ncs_i", i_acc, -64658);
        chk("ncs_q", q_acc, -64658);
        chk("ncs_sym", symbol, 3);
        for (int k = 0; k < 8; k++) step(1, 0, cos_tab[k]);
        chk("b2b_i", i_acc, 64658);
        chk("b2b_sym", symbol, 0);

        // cos symbol with gaps of 1-3 idle cycles between samples
        for (int k = 0; k < 8; k++) begin
            step(1, 0, cos_tab[k]);
            if (k < 7) begin
                chk("gap_no_early_sv", sym_valid, 0);
                for (int g = 0; g < int'($urandom_range(3, 1)); g++) step(0, 0, 0);
            end
        end
        chk("gap_sv", sym_valid, 1);
        chk("gap_i", i_acc, 64658);
        chk("gap_q", q_acc, 0);

        // partial symbol discarded by align carrying a sample
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step(1, 0, int'($urandom_range(1023)) - 512);
            if (sym_valid) pulses++;
        end
        step(1, 1, 127);
        if (sym_valid) pulses++;
        for (int k = 1; k < 8; k++) begin
            step(1, 0, cos_tab[k]);
            if (sym_valid) pulses++;
        end
        chk("align_pulses", pulses, 1);
        chk("align_i", i_acc, 64658);

        // align coinciding with a phase-7 sample wins
        for (int k = 0; k < 7; k++) step(1, 0, cos_tab[k]);
        step(1, 1, 127);
        chk("align_p7_sv", sym_valid, 0);
        for (int k = 1; k < 8; k++) step(1, 0, cos_tab[k]);
        chk("align_p7_i", i_acc, 64658);

        // reset mid-symbol
        for (int k = 0; k < 4; k++) step(1, 0, -sin_tab[k]);
        sample_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1, 0, -(cos_tab[k] + sin_tab[k]));
            if (k < 7) chk("rst_no_early_sv", sym_valid, 0);
        end
        chk("rst_sv", sym_valid, 1);
        chk("rst_i", i_acc, -64658);
        chk("rst_sym", symbol, 3);

        // random traffic, including extreme sample values
        for (int n = 0; n < 600; n++) begin
            v = int'($urandom_range(1023)) - 512;
            if ($urandom_range(9) == 0) v = ($urandom_range(1) == 0) ? -512 : 511;
            step($urandom_range(3) != 0, $urandom_range(24) == 0, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qpsk_demodulator.md
QPSK_DEMODULATOR -- requirements
Module: qpsk_demodulator

Interface
REQ-001 The block SHALL have one parameter, DATA_W, default 10: signed input sample width, equal to the modulator output width.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port QPSK_in, input, DATA_W bits, signed: modulated sample stream from the modulator stage.
REQ-005 The block SHALL have port sample_valid, input, 1 bit: QPSK_in is accepted on an edge where this is 1.
REQ-006 The block SHALL have port align, input, 1 bit: symbol-boundary realign strobe.
REQ-007 The block SHALL have port i_acc, output, 21 bits, signed: registered I correlation result of the last symbol.
REQ-008 The block SHALL have port q_acc, output, 21 bits, signed: registered Q correlation result of the last symbol.
REQ-009 The block SHALL have port symbol, output, 2 bits: decided symbol {I_bit,Q_bit}.
REQ-010 The block SHALL have port sym_valid, output, 1 bit: one-cycle strobe marking new i_acc/q_acc/symbol.

Function
REQ-011 A symbol SHALL span exactly 8 accepted samples, tracked by a 3-bit phase counter (0..7) that advances only on accepted samples.
REQ-012 The reference LUTs SHALL be cos = {127,90,0,-90,-127,-90,0,90} and sin = {0,90,127,90,0,-90,-127,-90}, indexed by phase.
REQ-013 Each accepted sample SHALL be multiplied by cos[phase] and by sin[phase] as signed values (18-bit products, sign-extended to 21 bits) and added to internal I and Q running sums.
REQ-014 Arithmetic SHALL be full precision with no saturation; 21 bits covers the worst case 8*512*127.
REQ-015 On the edge accepting a phase-7 sample, the block SHALL load i_acc/q_acc with the final sums including that sample, update symbol, and set sym_valid=1 for exactly one cycle.
REQ-016 On that same edge, the running sums SHALL clear and phase SHALL wrap to 0.
REQ-017 Latency SHALL be 0 cycles after the 8th sample edge; outputs are visible in the cycle immediately after that edge.
REQ-018 I_bit SHALL be the sign bit of the final I sum and Q_bit the sign bit of the final Q sum, so zero or positive decodes as 0.
REQ-019 Symbol mapping SHALL be 00 for (+,+), 01 for (+,-), 11 for (-,-), 10 for (-,+).
REQ-020 sample_valid=0 cycles (gaps) SHALL hold phase and sums unchanged, with any number of gaps allowed within a symbol.
REQ-021 If align=1 and sample_valid=0, phase SHALL become 0, sums SHALL clear, and no sym_valid SHALL be generated.
REQ-022 If align=1 and sample_valid=1 on the same edge, the sample SHALL be treated as phase 0: the sums load with only its products and phase becomes 1.
REQ-023 align during a partial symbol SHALL discard that partial symbol silently.
REQ-024 If align=1 coincides with a phase-7 sample, align SHALL win: no sym_valid, and the sample is taken as phase 0.
REQ-025 i_acc, q_acc and symbol SHALL hold their values between sym_valid strobes.
REQ-026 X or undefined handling is out of scope; inputs SHALL be treated as always defined.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force phase=0, sums=0, i_acc=0, q_acc=0, symbol=2'b00, sym_valid=0.
REQ-028 Reset asserted mid-symbol SHALL discard the partial symbol.
REQ-029 After rst_n deasserts, the first accepted sample SHALL be phase 0.
REQ-030 No sym_valid SHALL be produced until 8 samples have been accepted after reset.

Verification
REQ-031 The bench SHALL check: 8 valid samples equal to the cos LUT -> sym_valid for one cycle, i_acc=64658, q_acc=0, symbol=00.
REQ-032 The bench SHALL check: 8 samples equal to the negated sin LUT -> i_acc=0, q_acc=-64658, symbol=01.
REQ-033 The bench SHALL check: 8 samples of -(cos+sin) pattern -> i_acc=-64658, q_acc=-64658, symbol=11; then back-to-back next symbol with no gap is decoded correctly.
REQ-034 The bench SHALL check: cos-LUT symbol with sample_valid gaps of 1-3 cycles between samples -> identical result to REQ-031, and sym_valid appears only after the 8th accepted sample.
REQ-035 The bench SHALL check: 5 samples, then align with a valid sample, then 7 more cos-LUT samples (aligned sample = 127) -> exactly one sym_valid, i_acc=64658.
REQ-036 The bench SHALL check: rst_n pulsed low after 4 samples -> all outputs 0 immediately, and the next sym_valid occurs only after 8 fresh samples.
